// File: rtl/twiddle_pkg.sv
// Shared types for the twiddle pair sequencer: float word, cos/sin pair, FSM states.
package twiddle_pkg;

    localparam int EXP_LEN      = 8;
    localparam int MANTISSA_LEN = 23;
    localparam int FW           = EXP_LEN + MANTISSA_LEN + 1;

    typedef logic [FW-1:0] fp_word_t;

    typedef struct packed {
        fp_word_t cos;
        fp_word_t sin;
    } twiddle_pair_t;

    typedef enum logic {
        S_COS = 1'b0,
        S_SIN = 1'b1
    } seq_state_t;

endpackage

// File: rtl/twiddle_pair_fifo.sv
// Show-ahead FIFO of twiddle pairs. Head is visible whenever the FIFO is non-empty;
// push and pop may occur in the same cycle at any occupancy, including full.
module twiddle_pair_fifo
    import twiddle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  twiddle_pair_t                push_data,
    input  logic                         pop,
    output twiddle_pair_t                head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    twiddle_pair_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && !empty;
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    // Empty FIFO presents zeros so the head never shows stale storage.
    assign head   = empty ? '0 : mem[rd_ptr_q];

    // Storage write; pointers and count alone define which entries are live.
    // NOTE: storage has no reset -- it is never read while empty, and leaving it out keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full FIFO unless it pops too.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/twiddle_pair_sequencer.sv
// Feeds each angle to the sine calculator twice (cos then sin), pairs the results
// after the calculator's fixed latency and streams {cos, sin} out via a credit-metered FIFO.
module twiddle_pair_sequencer
    import twiddle_pkg::*;
#(
    parameter int CALC_LATENCY = 3,
    parameter int OUT_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  fp_word_t in_theta,
    output logic     calc_enable,
    output fp_word_t calc_theta,
    output logic     calc_sine_cosine,
    input  fp_word_t calc_value,
    output logic     out_valid,
    input  logic     out_ready,
    output fp_word_t out_cos,
    output fp_word_t out_sin
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    seq_state_t        state_q, state_d;
    logic              run_q;
    fp_word_t          theta_q;
    logic              issue_d, sc_d, take_credit, accept;
    fp_word_t          theta_d;
    logic [CNT_W-1:0]  in_flight_q, fifo_count;
    logic [CNT_W:0]    occupancy;
    logic [CALC_LATENCY-1:0] tag_vld_q, tag_sc_q;
    logic              wb_vld, wb_sc;
    fp_word_t          cos_hold_q;
    logic              push, pop, fifo_full, fifo_empty;
    twiddle_pair_t     push_pair, head_pair;

    // Output FIFO slots already filled plus pairs still inside the calculator.
    assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight_q};
    assign accept    = (state_q == S_COS) && in_valid && in_ready;

    // Next state and next calculator command.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        in_ready    = 1'b0;
        issue_d     = 1'b0;
        sc_d        = 1'b0;
        theta_d     = '0;
        take_credit = 1'b0;
        case (state_q)
            S_COS: begin
                in_ready = run_q && (occupancy < (CNT_W+1)'(OUT_DEPTH));
                if (in_valid && in_ready) begin
                    issue_d = 1'b1;
                    theta_d = in_theta;
                    state_d = S_SIN;
                end
            end
            S_SIN: begin
                issue_d     = 1'b1;
                sc_d        = 1'b1;
                theta_d     = theta_q;
                take_credit = 1'b1;
                state_d     = S_COS;
            end
            default: state_d = S_COS;
        endcase
    end

    // FSM state, latched angle and registered calculator command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_COS;
            run_q            <= 1'b0;
            theta_q          <= '0;
            calc_enable      <= 1'b0;
            calc_sine_cosine <= 1'b0;
            calc_theta       <= '0;
        end else begin
            state_q          <= state_d;
            run_q            <= 1'b1;
            if (accept) theta_q <= in_theta;
            calc_enable      <= issue_d;
            calc_sine_cosine <= sc_d;
            calc_theta       <= theta_d;
        end
    end

    // Tag pipe tracks which calculator result is arriving and whether it is cos or sin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_sc_q  <= '0;
        end else begin
            tag_vld_q[0] <= calc_enable;
            tag_sc_q[0]  <= calc_sine_cosine;
            for (int i = 1; i < CALC_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_sc_q[i]  <= tag_sc_q[i-1];
            end
        end
    end

    assign wb_vld    = tag_vld_q[CALC_LATENCY-1];
    assign wb_sc     = tag_sc_q[CALC_LATENCY-1];
    assign push      = wb_vld && wb_sc;
    assign push_pair = '{cos: cos_hold_q, sin: calc_value};

    // Cos result waits here until its sin partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_hold_q <= '0;
        end else if (wb_vld && !wb_sc) begin
            cos_hold_q <= calc_value;
        end
    end

    // Pairs in flight: taken on the sin issue, returned on the sin writeback; both may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= '0;
        end else begin
            case ({take_credit, push})
                2'b10:   in_flight_q <= in_flight_q + 1'b1;
                2'b01:   in_flight_q <= in_flight_q - 1'b1;
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_cos   = head_pair.cos;
    assign out_sin   = head_pair.sin;

    twiddle_pair_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_pair),
        .pop       (pop),
        .head      (head_pair),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Full is only meaningful to the FIFO's own overflow check; the credit count already covers it.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
